bcd_serial_addsub: RTL and testbench

Parametrised, digit-serial packed-BCD adder/subtractor for NDIGITS-digit operands. It processes one BCD digit per clock, LSD first, using a start/busy/done handshake. Subtraction uses ten's-complement. A negative result gets a second correction pass, so sum always holds a magnitude and neg holds the sign. It is the multi-digit, sequential successor to the team's fixed 2-digit combinational BCD adder, intended for counters/displays and calculator datapaths.

---
 rtl/bcd_serial_addsub.sv | 219 +++++++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// bcd_serial_addsub
//
// Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
// clock, least significant digit first. Subtraction is done by ten's
// complement. When a subtraction comes out negative, a second pass converts
// the complemented result back to a magnitude, so `sum` always holds a
// magnitude and `neg` holds the sign.
//
// Optional build macro: BCD_DIGIT_CHECK_EN
//   defined   : nibbles > 9 in a or b at acceptance are flagged. The operation
//               runs the first pass only, then reports err=1 with sum, cout
//               and neg forced to 0.
//   undefined : err is tied 0. Invalid nibbles simply flow through the digit
//               arithmetic.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   operation request, sampled only while idle
//   sub    in   0 = a+b, 1 = a-b (latched with start)
//   a, b   in   packed BCD operands, digit 0 in bits [3:0]
//   busy   out  high whenever an operation is in flight (state != IDLE)
//   done   out  one-cycle pulse; sum/cout/neg/err valid from this cycle
//   sum    out  packed BCD magnitude, held until the next accepted start
//   cout   out  decimal carry out of the MSD (add only)
//   neg    out  result sign (subtract with a < b)
//   err    out  invalid input digit detected
//
// State | Meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the previous result
// RUN   | first pass: one digit of a +/- b per clock
// FIX   | second pass for a negative subtract: sum digit -> 9 - digit (+c)
// DONE  | done pulse for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   neg,
  output logic                   err
);

  localparam int CW = $clog2(NDIGITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_q;
  logic [CW-1:0]              idx_q;
  logic                       c_q;
  logic                       sub_q;
  logic [NDIGITS-1:0][3:0]    a_q;
  logic [NDIGITS-1:0][3:0]    b_q;
  logic [NDIGITS-1:0][3:0]    sum_q;
  logic                       cout_q;
  logic                       neg_q;
  logic                       done_q;
  logic                       bad_q;
  logic                       err_q;

  // Single digit slice shared by both passes.
  int                         sel;
  logic [3:0]                 x_dig;
  logic [3:0]                 y_dig;
  logic [4:0]                 t_sum;
  logic [4:0]                 t_adj;
  logic [3:0]                 dig_d;
  logic                       c_d;

  always_comb begin
    sel = int'(idx_q);
    if (state_q == FIX) begin
      // Nine's complement of the stored digit; the +1 of ten's complement
      // enters through the carry, which FIX starts at 1.
      x_dig = 4'd9 - sum_q[sel];
      y_dig = 4'd0;
    end else begin
      x_dig = a_q[sel];
      y_dig = sub_q ? (4'd9 - b_q[sel]) : b_q[sel];
    end
    t_sum = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, c_q};
    t_adj = t_sum + 5'd6;
    if (t_sum > 5'd9) begin
      dig_d = t_adj[3:0];
      c_d   = 1'b1;
    end else begin
      dig_d = t_sum[3:0];
      c_d   = 1'b0;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int k = 0; k < NDIGITS; k++) begin
      if ((a[4*k +: 4] > 4'd9) || (b[4*k +: 4] > 4'd9)) bad_in = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      bad_q <= bad_in;
      err_q <= 1'b0;
    end else if ((state_q == RUN) && (idx_q == LAST) && bad_q) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bad_q = 1'b0;
  assign err_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            c_q     <= sub;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            state_q <= RUN;
          end
        end

        RUN: begin
          sum_q[sel] <= dig_d;
          c_q        <= c_d;
          idx_q      <= idx_q + CW'(1);
          if (idx_q == LAST) begin
            idx_q <= '0;
            if (bad_q) begin
              // Invalid operand: report the error with a cleared result.
              sum_q   <= '0;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (!sub_q) begin
              cout_q  <= c_d;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (c_d) begin
              // Final carry out of a ten's-complement subtract: a >= b.
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              neg_q   <= 1'b1;
              c_q     <= 1'b1;
              state_q <= FIX;
            end
          end
        end

        FIX: begin
          sum_q[sel] <= dig_d;
          c_q        <= c_d;
          idx_q      <= idx_q + CW'(1);
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_addsub
//
// Self-checking bench for bcd_serial_addsub with NDIGITS = 4. Expected values
// come from directed constants and from a decimal integer model (BCD is
// converted to integers, added/subtracted, converted back).
// -----------------------------------------------------------------------------
module tb_bcd_serial_addsub;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         neg;
  logic         err;

  int tests_run    = 0;
  int tests_failed = 0;

  bcd_serial_addsub #(.NDIGITS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r;
    r = 0;
    for (int k = N - 1; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r;
    longint       x;
    r = '0;
    x = v;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, output logic [W-1:0] es,
                       output logic ec, output logic en, output int elat);
    longint x, y, lim;
    x = bcd2int(av);
    y = bcd2int(bv);
    lim = 1;
    for (int k = 0; k < N; k++) lim = lim * 10;
    if (!sv) begin
      es = int2bcd((x + y) % lim); ec = ((x + y) >= lim); en = 1'b0; elat = N + 1;
    end else if (x >= y) begin
      es = int2bcd(x - y); ec = 1'b0; en = 1'b0; elat = N + 1;
    end else begin
      es = int2bcd(y - x); ec = 1'b0; en = 1'b1; elat = 2 * N + 1;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // ------------------------------------------------------------ stimulus
  // Runs one operation. lat is the edge number (accept edge = 1) after which
  // done was first seen. glitch pulses start for the edge with that number;
  // hold_done holds start high across the done cycle.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input int glitch, input bit hold_done,
                       output logic [W-1:0] s, output logic co,
                       output logic ng, output logic er, output int lat,
                       output bit busy_ok, output bit pulse_ok);
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = ~sv;
    lat = 1;
    busy_ok = (busy === 1'b1);
    pulse_ok = 1'b0;
    s = '0; co = 1'b0; ng = 1'b0; er = 1'b0;
    while (lat < 40) begin
      if (lat + 1 == glitch) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
    end
    if (done === 1'b1) begin
      s = sum; co = cout; ng = neg; er = err;
      if (hold_done) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulse_ok = (done === 1'b0) && (busy === 1'b0) && (sum === s);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({sum, cout, neg, err, done, busy} !== '0)
      begin tests_failed++; $display("FAIL reset_state: got sum=%h cout=%b neg=%b err=%b done=%b busy=%b, want all 0", sum, cout, neg, err, done, busy); end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0)
      begin tests_failed++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6] = '{16'h1234, 16'h9999, 16'h0999, 16'h5000, 16'h4321, 16'h0123};
    logic [W-1:0] tb[6] = '{16'h5678, 16'h0001, 16'h0001, 16'h1234, 16'h4321, 16'h4567};
    logic         ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] xs[6] = '{16'h6912, 16'h0000, 16'h1000, 16'h3766, 16'h0000, 16'h4444};
    logic         xc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         xn[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int           xl[6] = '{5, 5, 5, 5, 5, 9};
    logic [W-1:0] s;
    logic         co, ng, er;
    int           lat;
    bit           bok, pok;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], ts[i], 0, 1'b0, s, co, ng, er, lat, bok, pok);
      tests_run++;
      if ({s, co, ng, er} !== {xs[i], xc[i], xn[i], 1'b0})
        begin tests_failed++; $display("FAIL directed_%0d result: got sum=%h cout=%b neg=%b err=%b, want sum=%h cout=%b neg=%b err=0", i, s, co, ng, er, xs[i], xc[i], xn[i]); end
      tests_run++;
      if ((lat !== xl[i]) || !bok || !pok)
        begin tests_failed++; $display("FAIL directed_%0d timing: got done at edge %0d busy_ok=%0d pulse_ok=%0d, want edge %0d 1 1", i, lat, bok, pok, xl[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, s, es;
    logic         sv, co, ng, er, ec, en;
    int           lat, elat;
    bit           bok, pok;
    for (int i = 0; i < 40; i++) begin
      av = rand_bcd();
      bv = (i % 8 == 3) ? av : rand_bcd();
      sv = 1'($urandom_range(0, 1));
      model(av, bv, sv, es, ec, en, elat);
      do_op(av, bv, sv, 0, 1'b0, s, co, ng, er, lat, bok, pok);
      tests_run++;
      if ({s, co, ng, er} !== {es, ec, en, 1'b0} || lat !== elat || !bok || !pok)
        begin tests_failed++; $display("FAIL random_%0d a=%h b=%h sub=%b: got sum=%h cout=%b neg=%b err=%b edge=%0d bok=%0d pok=%0d, want sum=%h cout=%b neg=%b err=0 edge=%0d", i, av, bv, sv, s, co, ng, er, lat, bok, pok, es, ec, en, elat); end
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] s;
    logic         co, ng, er;
    int           lat;
    bit           bok, pok;
    do_op(16'h0123, 16'h4567, 1'b1, 3, 1'b0, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if ({s, co, ng} !== {16'h4444, 1'b0, 1'b1} || lat !== 9 || !bok || !pok)
      begin tests_failed++; $display("FAIL start_ignored: got sum=%h cout=%b neg=%b edge=%0d bok=%0d pok=%0d, want sum=4444 cout=0 neg=1 edge=9", s, co, ng, lat, bok, pok); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic         co, ng, er;
    int           lat;
    bit           bok, pok;
    // start held through the done cycle must not launch a new operation.
    do_op(16'h0042, 16'h0058, 1'b0, 0, 1'b1, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if (s !== 16'h0100 || lat !== 5 || !pok)
      begin tests_failed++; $display("FAIL back_to_back_1: got sum=%h edge=%0d pulse_ok=%0d, want sum=0100 edge=5 pulse_ok=1", s, lat, pok); end
    do_op(16'h0100, 16'h0101, 1'b1, 0, 1'b0, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if ({s, co, ng} !== {16'h0001, 1'b0, 1'b1} || lat !== 9 || !bok || !pok)
      begin tests_failed++; $display("FAIL back_to_back_2: got sum=%h cout=%b neg=%b edge=%0d, want sum=0001 cout=0 neg=1 edge=9", s, co, ng, lat); end
  endtask

  task automatic test_midrun_reset();
    logic [W-1:0] s;
    logic         co, ng, er;
    int           lat;
    bit           bok, pok, seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    tests_run++;
    if (sum !== 16'h0012 || busy !== 1'b1)
      begin tests_failed++; $display("FAIL midrun_partial: got sum=%h busy=%b, want sum=0012 busy=1", sum, busy); end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({sum, cout, neg, err, done, busy} !== '0)
      begin tests_failed++; $display("FAIL midrun_reset: got sum=%h cout=%b neg=%b err=%b done=%b busy=%b, want all 0", sum, cout, neg, err, done, busy); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen)
      begin tests_failed++; $display("FAIL midrun_no_done: got done/busy activity=%0d after reset, want 0", seen); end
    do_op(16'h0005, 16'h0005, 1'b0, 0, 1'b0, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if ({s, co, ng} !== {16'h0010, 1'b0, 1'b0} || lat !== 5)
      begin tests_failed++; $display("FAIL midrun_restart: got sum=%h cout=%b neg=%b edge=%0d, want sum=0010 cout=0 neg=0 edge=5", s, co, ng, lat); end
  endtask

  task automatic test_invalid();
    logic [W-1:0] s;
    logic         co, ng, er;
    int           lat;
    bit           bok, pok;
    do_op(16'h12A4, 16'h0001, 1'b0, 0, 1'b0, s, co, ng, er, lat, bok, pok);
`ifdef BCD_DIGIT_CHECK_EN
    tests_run++;
    if ({s, co, ng, er} !== {16'h0000, 1'b0, 1'b0, 1'b1} || lat !== 5)
      begin tests_failed++; $display("FAIL invalid_add: got sum=%h cout=%b neg=%b err=%b edge=%0d, want sum=0000 cout=0 neg=0 err=1 edge=5", s, co, ng, er, lat); end
    do_op(16'h0000, 16'h00F0, 1'b1, 0, 1'b0, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if ({s, co, ng, er} !== {16'h0000, 1'b0, 1'b0, 1'b1} || lat !== 5)
      begin tests_failed++; $display("FAIL invalid_sub: got sum=%h cout=%b neg=%b err=%b edge=%0d, want sum=0000 cout=0 neg=0 err=1 edge=5", s, co, ng, er, lat); end
    do_op(16'h0007, 16'h0002, 1'b0, 0, 1'b0, s, co, ng, er, lat, bok, pok);
    tests_run++;
    if ({s, er} !== {16'h0009, 1'b0})
      begin tests_failed++; $display("FAIL invalid_clear: got sum=%h err=%b, want sum=0009 err=0", s, er); end
`else
    tests_run++;
    if (er !== 1'b0 || lat !== 5)
      begin tests_failed++; $display("FAIL invalid_nocheck: got err=%b edge=%0d, want err=0 edge=5", er, lat); end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_midrun_reset();
    test_invalid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
